// File: rtl/pipe_stall_ctrl_if.sv
// Stall-controller bundle: cache miss/ready handshakes and hazard inputs in,
// stage-register write enables, flush/bubble and status out.
interface pipe_stall_ctrl_if;
  logic        icache_miss;
  logic        icache_ready;
  logic        dcache_miss;
  logic        dcache_ready;
  logic        load_use;
  logic        branch_taken;
  logic        pc_we;
  logic        if_id_we;
  logic        id_ex_we;
  logic        ex_mem_we;
  logic        mem_wb_we;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic [31:0] stall_count;
  logic        timeout_err;

  // Controller side.
  modport master (
    input  icache_miss, icache_ready, dcache_miss, dcache_ready, load_use, branch_taken,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_bubble,
    output stall_count, timeout_err
  );

  // Datapath / cache side.
  modport slave (
    output icache_miss, icache_ready, dcache_miss, dcache_ready, load_use, branch_taken,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_bubble,
    input  stall_count, timeout_err
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: freezes, bubbles or flushes stage registers on cache
// misses and hazards, counts stalled cycles and flags miss timeouts.
module pipe_stall_ctrl #(
  parameter int unsigned MISS_TIMEOUT = 255
) (
  input logic                i_clk,
  input logic                i_reset,
  pipe_stall_ctrl_if.master  io_bus
);

  typedef enum logic [1:0] {StRun, StDmiss, StImiss} state_e;

  localparam logic [7:0]  TimeoutCnt = 8'(MISS_TIMEOUT);
  localparam logic [31:0] CountMax   = 32'hFFFF_FFFF;

  // Enable vector order: {pc, if_id, id_ex, ex_mem, mem_wb}.
  localparam logic [4:0] WeNormal = 5'b11111;
  localparam logic [4:0] WeFreeze = 5'b00000;
  localparam logic [4:0] WeImiss  = 5'b01111;
  localparam logic [4:0] WeLdUse  = 5'b00111;

  state_e      r_state;
  logic        r_imiss_pend;
  logic        r_imiss_done;
  logic [7:0]  r_wait_cnt;
  logic [31:0] r_stall_count;
  logic        r_timeout_err;

  state_e      w_state_d;
  logic        w_imiss_pend_d;
  logic        w_imiss_done_d;
  logic [7:0]  w_wait_cnt_d;
  logic [4:0]  w_we;
  logic        w_flush;
  logic        w_bubble;
  logic        w_fill_seen;

  // A fill arriving on the same cycle as the D-fill still counts as seen.
  assign w_fill_seen = r_imiss_done | io_bus.icache_ready;

  always_comb begin
    w_state_d      = r_state;
    w_imiss_pend_d = r_imiss_pend;
    w_imiss_done_d = r_imiss_done;
    w_we           = WeNormal;
    w_flush        = 1'b0;
    w_bubble       = 1'b0;

    case (r_state)
      StRun: begin
        if (io_bus.dcache_miss) begin
          w_we      = WeFreeze;
          w_state_d = StDmiss;
          if (io_bus.icache_miss) w_imiss_pend_d = 1'b1;
        end else if (io_bus.icache_miss) begin
          w_we      = WeImiss;
          w_flush   = 1'b1;
          w_state_d = StImiss;
        end else if (io_bus.branch_taken) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
        end else if (io_bus.load_use) begin
          w_we     = WeLdUse;
          w_bubble = 1'b1;
        end
      end

      StDmiss: begin
        if (io_bus.dcache_ready) begin
          w_imiss_pend_d = 1'b0;
          w_imiss_done_d = 1'b0;
          if (r_imiss_pend && !w_fill_seen) begin
            w_we      = WeImiss;
            w_flush   = 1'b1;
            w_state_d = StImiss;
          end else begin
            w_state_d = StRun;
          end
        end else begin
          w_we = WeFreeze;
          if (io_bus.icache_ready) w_imiss_done_d = 1'b1;
        end
      end

      StImiss: begin
        if (io_bus.dcache_miss) begin
          w_we           = WeFreeze;
          w_imiss_pend_d = 1'b1;
          w_state_d      = StDmiss;
          if (io_bus.icache_ready) w_imiss_done_d = 1'b1;
        end else if (io_bus.icache_ready) begin
          w_state_d = StRun;
        end else begin
          w_we    = WeImiss;
          w_flush = 1'b1;
        end
      end

      default: begin
        w_we      = WeFreeze;
        w_state_d = StRun;
      end
    endcase
  end

  always_comb begin
    if (w_state_d != r_state && w_state_d != StRun) begin
      w_wait_cnt_d = 8'd0;
    end else if (r_state != StRun && r_wait_cnt != 8'hFF) begin
      w_wait_cnt_d = r_wait_cnt + 8'd1;
    end else begin
      w_wait_cnt_d = r_wait_cnt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= StRun;
      r_imiss_pend  <= 1'b0;
      r_imiss_done  <= 1'b0;
      r_wait_cnt    <= 8'd0;
      r_stall_count <= 32'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_imiss_pend <= w_imiss_pend_d;
      r_imiss_done <= w_imiss_done_d;
      r_wait_cnt   <= w_wait_cnt_d;
      if (r_wait_cnt == TimeoutCnt) r_timeout_err <= 1'b1;
      if (!w_we[4] && r_stall_count != CountMax) r_stall_count <= r_stall_count + 32'd1;
    end
  end

  // Reset holds every stage register frozen.
  always_comb begin
    io_bus.pc_we        = w_we[4] & ~i_reset;
    io_bus.if_id_we     = w_we[3] & ~i_reset;
    io_bus.id_ex_we     = w_we[2] & ~i_reset;
    io_bus.ex_mem_we    = w_we[1] & ~i_reset;
    io_bus.mem_wb_we    = w_we[0] & ~i_reset;
    io_bus.if_id_flush  = w_flush & ~i_reset;
    io_bus.id_ex_bubble = w_bubble & ~i_reset;
    io_bus.stall_count  = r_stall_count;
    io_bus.timeout_err  = r_timeout_err;
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: one DUT at the default timeout and one at
// MISS_TIMEOUT=4, both fed the same stimulus.
module tb_pipe_stall_ctrl;

  localparam logic [6:0] ONorm = 7'b11111_00;
  localparam logic [6:0] OFrz  = 7'b00000_00;
  localparam logic [6:0] OImis = 7'b01111_10;
  localparam logic [6:0] OLdUs = 7'b00111_01;
  localparam logic [6:0] OBr   = 7'b11111_11;
  localparam logic [6:0] ORst  = 7'b00000_00;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  pipe_stall_ctrl_if bus ();
  pipe_stall_ctrl_if bus4 ();

  assign bus4.icache_miss  = bus.icache_miss;
  assign bus4.icache_ready = bus.icache_ready;
  assign bus4.dcache_miss  = bus.dcache_miss;
  assign bus4.dcache_ready = bus.dcache_ready;
  assign bus4.load_use     = bus.load_use;
  assign bus4.branch_taken = bus.branch_taken;

  pipe_stall_ctrl #(.MISS_TIMEOUT(255)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  pipe_stall_ctrl #(.MISS_TIMEOUT(4)) dut4 (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus4)
  );

  wire [6:0] w_out  = {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we,
                       bus.if_id_flush, bus.id_ex_bubble};
  wire [6:0] w_out4 = {bus4.pc_we, bus4.if_id_we, bus4.id_ex_we, bus4.ex_mem_we,
                       bus4.mem_wb_we, bus4.if_id_flush, bus4.id_ex_bubble};

  always #5 clk = ~clk;

  task automatic set_in(input logic im, input logic ir, input logic dm, input logic dr,
                        input logic lu, input logic br);
    bus.icache_miss  = im;
    bus.icache_ready = ir;
    bus.dcache_miss  = dm;
    bus.dcache_ready = dr;
    bus.load_use     = lu;
    bus.branch_taken = br;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    set_in(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (w_out !== ORst) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", w_out, ORst);
    end
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (w_out !== ONorm) begin
        n_fail++; $display("FAIL idle_outputs c%0d: got %b expected %b", c, w_out, ONorm);
      end
      next_cycle();
    end
    @(negedge clk);
    n_checks++;
    if (bus.stall_count !== 32'd0 || bus.timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL idle_status: got count %0d err %b expected 0 0",
                         bus.stall_count, bus.timeout_err);
    end
  endtask

  task automatic test_dmiss();
    logic [6:0] exp;
    pulse_reset();
    for (int c = 0; c <= 5; c++) begin
      set_in(0, 0, c == 0, c == 5, 0, 0);
      exp = (c < 5) ? OFrz : ONorm;
      @(negedge clk);
      n_checks++;
      if (w_out !== exp) begin
        n_fail++; $display("FAIL dmiss c%0d: got %b expected %b", c, w_out, exp);
      end
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (w_out !== ONorm || bus.stall_count !== 32'd5) begin
      n_fail++; $display("FAIL dmiss_after: got %b/%0d expected %b/5", w_out, bus.stall_count,
                         ONorm);
    end
    next_cycle();
  endtask

  task automatic test_imiss();
    logic [6:0] exp;
    pulse_reset();
    for (int c = 0; c <= 3; c++) begin
      // Branch on the miss cycle is covered by the fetch flush.
      set_in(c == 0, c == 3, 0, 0, 0, c == 0);
      exp = (c < 3) ? OImis : ONorm;
      @(negedge clk);
      n_checks++;
      if (w_out !== exp) begin
        n_fail++; $display("FAIL imiss c%0d: got %b expected %b", c, w_out, exp);
      end
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (w_out !== ONorm || bus.stall_count !== 32'd3) begin
      n_fail++; $display("FAIL imiss_after: got %b/%0d expected %b/3", w_out, bus.stall_count,
                         ONorm);
    end
    next_cycle();
  endtask

  task automatic test_imiss_under_dmiss();
    logic [6:0] exp;
    pulse_reset();
    for (int c = 0; c <= 6; c++) begin
      set_in(c == 0, c == 3, c == 2, c == 6, 0, 0);
      exp = (c < 2) ? OImis : (c < 6) ? OFrz : ONorm;
      @(negedge clk);
      n_checks++;
      if (w_out !== exp) begin
        n_fail++; $display("FAIL nested c%0d: got %b expected %b", c, w_out, exp);
      end
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (w_out !== ONorm || bus.stall_count !== 32'd6) begin
      n_fail++; $display("FAIL nested_after: got %b/%0d expected %b/6", w_out, bus.stall_count,
                         ONorm);
    end
    next_cycle();
  endtask

  task automatic test_hazards();
    pulse_reset();
    set_in(0, 0, 0, 0, 1, 1);
    @(negedge clk);
    n_checks++;
    if (w_out !== OBr) begin
      n_fail++; $display("FAIL br_over_lu: got %b expected %b", w_out, OBr);
    end
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      set_in(0, 0, 0, 0, 1, 0);
      @(negedge clk);
      n_checks++;
      if (w_out !== OLdUs) begin
        n_fail++; $display("FAIL load_use c%0d: got %b expected %b", c, w_out, OLdUs);
      end
      next_cycle();
    end
    // Stray ready pulses in RUN change nothing.
    set_in(0, 1, 0, 1, 0, 0);
    @(negedge clk);
    n_checks++;
    if (w_out !== ONorm || bus.stall_count !== 32'd2) begin
      n_fail++; $display("FAIL hazard_after: got %b/%0d expected %b/2", w_out, bus.stall_count,
                         ONorm);
    end
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (w_out !== ONorm || bus.stall_count !== 32'd2) begin
      n_fail++; $display("FAIL stray_ready: got %b/%0d expected %b/2", w_out, bus.stall_count,
                         ONorm);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    logic exp_err;
    pulse_reset();
    for (int c = 0; c <= 9; c++) begin
      set_in(0, 0, 1, 0, 0, 0);
      exp_err = (c >= 6);
      @(negedge clk);
      n_checks++;
      if (w_out4 !== OFrz || bus4.timeout_err !== exp_err) begin
        n_fail++; $display("FAIL timeout c%0d: got %b/%b expected %b/%b", c, w_out4,
                           bus4.timeout_err, OFrz, exp_err);
      end
      next_cycle();
    end
    set_in(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    n_checks++;
    if (w_out4 !== ONorm || bus4.timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_ready: got %b/%b expected %b/1", w_out4,
                         bus4.timeout_err, ONorm);
    end
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (w_out4 !== ONorm || bus4.timeout_err !== 1'b1 || bus4.stall_count !== 32'd10) begin
      n_fail++; $display("FAIL timeout_sticky: got %b/%b/%0d expected %b/1/10", w_out4,
                         bus4.timeout_err, bus4.stall_count, ONorm);
    end
    n_checks++;
    if (bus.timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_default: got %b expected 0", bus.timeout_err);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_miss();
    // No reset pulse first: dut4 still carries the timeout flag from before.
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, c == 0, 0, 0, 0);
      @(negedge clk);
      n_checks++;
      if (w_out !== OFrz) begin
        n_fail++; $display("FAIL rst_miss c%0d: got %b expected %b", c, w_out, OFrz);
      end
      next_cycle();
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (w_out !== ORst) begin
      n_fail++; $display("FAIL rst_hold: got %b expected %b", w_out, ORst);
    end
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      set_in(0, 0, 0, c == 1, 0, 0);
      @(negedge clk);
      n_checks++;
      if (w_out !== ONorm || bus.stall_count !== 32'd0 || bus4.stall_count !== 32'd0 ||
          bus4.timeout_err !== 1'b0) begin
        n_fail++; $display("FAIL rst_after c%0d: got %b/%0d/%0d/%b expected %b/0/0/0", c, w_out,
                           bus.stall_count, bus4.stall_count, bus4.timeout_err, ONorm);
      end
      next_cycle();
    end
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    n_checks = 0;
    n_fail   = 0;
    set_in(0, 0, 0, 0, 0, 0);
    next_cycle();
    test_reset();
    test_dmiss();
    test_imiss();
    test_imiss_under_dmiss();
    test_hazards();
    test_timeout();
    test_reset_mid_miss();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush controller that drives the write enables of the pipeline stage registers: PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It consumes cache miss/ready handshakes and hazard indications, then freezes, bubbles or flushes stages. It also keeps a stall-cycle performance counter and a miss-timeout error flag. It sits beside the datapath in the CPU top level, between the I/D caches (victim-cache hierarchy) and the stage registers.

## Interface
- MISS_TIMEOUT, 255: cycles spent waiting on a miss before timeout_err sets; 1..255.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- icache_miss  input  1  fetch missed this cycle.
- icache_ready  input  1  fetch miss fill complete; single-cycle pulse.
- dcache_miss  input  1  MEM-stage access missed this cycle.
- dcache_ready  input  1  data miss fill complete; single-cycle pulse.
- load_use  input  1  ID instruction depends on the load in EX.
- branch_taken  input  1  taken branch resolved in EX.
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  output  1 each  stage register write enables.
- if_id_flush  output  1  IF/ID loads NOP this cycle; only meaningful with if_id_we=1.
- id_ex_bubble  output  1  ID/EX loads NOP this cycle; only meaningful with id_ex_we=1.
- stall_count  output  32  cycles with pc_we=0 since reset; saturates at 0xFFFF_FFFF.
- timeout_err  output  1  sticky miss-timeout flag.

## Operation
- Registered state:
  - FSM: RUN, DMISS, IMISS.
  - imiss_pend: an I-miss is outstanding under a D-miss.
  - imiss_done: icache_ready was seen while in DMISS.
  - 8-bit wait_cnt.
  - stall_count.
  - timeout_err.
- The enable, flush and bubble outputs are combinational from state and inputs (Mealy). A stall therefore takes effect in the same cycle it is detected.
- Full freeze: all five *_we=0, flush=0, bubble=0.
- Normal: all *_we=1, flush=0, bubble=0.
- RUN, priority highest first:
  - dcache_miss: full freeze; next state DMISS. If icache_miss is also high, set imiss_pend.
  - icache_miss: pc_we=0, if_id_we=1 with if_id_flush=1, downstream stages enabled; next state IMISS. If branch_taken is also high, the flush covers it.
  - branch_taken: normal enables plus if_id_flush=1 and id_ex_bubble=1. This overrides load_use.
  - load_use: pc_we=0, if_id_we=0, id_ex_we=1 with id_ex_bubble=1, ex_mem_we=mem_wb_we=1. No state change; the stall lasts exactly as long as load_use stays high.
  - Otherwise: normal.
- DMISS:
  - Full freeze every cycle that dcache_ready=0.
  - On the dcache_ready cycle:
    - If imiss_pend=1 and imiss_done=0: IMISS outputs this cycle; next state IMISS.
    - Otherwise: normal outputs; next state RUN.
    - In both cases imiss_pend and imiss_done clear.
  - icache_ready while in DMISS sets imiss_done; the fill is not lost.
- IMISS:
  - pc_we=0, if_id_flush=1, other enables 1, until icache_ready.
  - The icache_ready cycle gives normal outputs; next state RUN.
  - dcache_miss in IMISS: full freeze, set imiss_pend, next state DMISS. If icache_ready arrives in the same cycle, dcache_miss wins and imiss_done sets.
- wait_cnt:
  - Clears on every transition into DMISS or IMISS.
  - Increments each cycle spent in DMISS or IMISS, saturating at 255.
  - When wait_cnt = MISS_TIMEOUT: timeout_err sets. It stays set until reset.
  - The FSM keeps waiting regardless of timeout_err.
- stall_count increments on every non-reset cycle where pc_we=0.

## Timing
- Reset (synchronous):
  - Next edge state: RUN, wait_cnt=0, stall_count=0, timeout_err=0, imiss_pend=imiss_done=0.
  - While reset=1, all *_we=0 and if_id_flush=id_ex_bubble=0.
  - Reset asserted during DMISS or IMISS abandons the miss.
- Miss latency: a miss asserted at cycle 0 with ready at cycle N gives N cycles of stall (cycles 0..N-1). Cycle N advances.
- Load-use: one stall cycle per cycle of load_use.
- Ready pulses outside the matching wait state are ignored.
- Miss inputs are ignored while already in the matching wait state.

## Test plan
- Reset, then idle inputs for 3 cycles -> all *_we=1, flush=bubble=0, stall_count=0, timeout_err=0.
- dcache_miss at cycle 0, dcache_ready at cycle 5 -> full freeze in cycles 0..4, normal in cycle 5, state RUN, stall_count=5.
- icache_miss at cycle 0, dcache_miss at cycle 2, icache_ready at cycle 3, dcache_ready at cycle 6:
  - Cycles 0..1 show IMISS outputs; cycles 2..5 full freeze.
  - Cycle 6 is normal with no return to IMISS.
  - stall_count=6.
- load_use and branch_taken together for one cycle -> pc_we=1, if_id_flush=1, id_ex_bubble=1, stall_count unchanged.
- MISS_TIMEOUT=4, dcache_miss with no ready for 10 cycles -> timeout_err rises after wait_cnt reaches 4 and stays high. A later dcache_ready returns the FSM to RUN with timeout_err still 1.
- Reset asserted in cycle 3 of a DMISS -> next cycle state RUN, all outputs normal, counters 0, timeout_err 0.
